rv_mem_arb: RTL and testbench
=============================

// Module: rv_mem_arb
// PURPOSE
//  Shares one single-port synchronous memory (1-cycle read latency) between the
//  instruction-fetch port and the data-memory port of the 5-stage core.
//  Sits between rv_cpu (imem/dmem interfaces) and a unified memory macro.
//  Grants at most one request per cycle and routes returning read data to its owner.
//  Data port has priority; an optional starvation guard bounds fetch wait.
// PARAMETERS
//  ADDR_W        32  address width, both ports and memory
//  DATA_W        32  data width; byte enables are DATA_W/8 bits
//  MAX_DM_BURST  4   consecutive data grants tolerated while fetch waits (guard only)
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         synchronous reset, active high
//  if_req_valid   in   1         fetch read request
//  if_req_addr    in   ADDR_W    fetch address
//  if_req_ready   out  1         fetch granted this cycle
//  if_rsp_valid   out  1         fetch read data valid
//  if_rsp_data    out  DATA_W    fetch read data
//  dm_req_valid   in   1         data request (read or write)
//  dm_req_addr    in   ADDR_W    data address
//  dm_req_wr_en   in   1         1 = write, 0 = read
//  dm_req_wr_data in   DATA_W    write data
//  dm_req_be      in   DATA_W/8  byte enables (writes only)
//  dm_req_ready   out  1         data request granted this cycle
//  dm_rsp_valid   out  1         data read data valid
//  dm_rsp_data    out  DATA_W    data read data
//  mem_rd_en      out  1         memory read strobe
//  mem_wr_en      out  1         memory write strobe
//  mem_addr       out  ADDR_W    memory address
//  mem_wr_data    out  DATA_W    memory write data
//  mem_be         out  DATA_W/8  memory byte enables
//  mem_rd_data    in   DATA_W    memory read data, valid 1 cycle after mem_rd_en
// BEHAVIOUR
//  - Grant (combinational, same cycle): gnt_dm = dm_req_valid & ~force_if;
//    gnt_if = if_req_valid & ~gnt_dm. While rst=1 both grants and mem strobes = 0.
//  - Memory drive: gnt_dm -> addr/wr_data/be from dm port, mem_wr_en=dm_req_wr_en,
//    mem_rd_en=~dm_req_wr_en; gnt_if -> addr=if_req_addr, mem_rd_en=1, be=all ones;
//    no grant -> mem_rd_en=mem_wr_en=0, addr/wr_data/be = 0.
//  - Response owner register rsp_sel_q {NONE,IF,DM}: next = IF on gnt_if, DM on
//    read gnt_dm, NONE on write or idle. Reset value NONE.
//  - if_rsp_valid = (rsp_sel_q==IF); dm_rsp_valid = (rsp_sel_q==DM); both rsp_data
//    outputs = mem_rd_data (qualified only by valid). Read latency exactly 1 cycle.
//  - Back-to-back grants every cycle allowed; response of cycle N overlaps grant N+1.
//  - Writes produce no response; read-after-write same address next cycle sees new data
//    (memory property, arbiter adds no buffering).
//  - Requester must hold valid/addr/data stable until ready; arbiter has no request queue.
//  - Reset mid-operation: pending response dropped (rsp_sel_q=NONE, valids 0 next cycle).
//  - Reset values: all *_ready, *_rsp_valid, mem strobes = 0; rsp_sel_q=NONE; starve_cnt=0.
// CONFIGURATION
//  MEM_ARB_STARVE_GUARD_EN defined:
//   - starve_cnt ($clog2(MAX_DM_BURST+1) bits): +1 on each gnt_dm while if_req_valid=1;
//     cleared on gnt_if or when if_req_valid=0; saturates at MAX_DM_BURST.
//   - force_if = if_req_valid & (starve_cnt==MAX_DM_BURST): fetch wins that cycle,
//     dm_req_ready=0, counter clears.
//  Not defined: force_if tied 0, no counter; strict data priority (fetch may starve).
// TESTING
//  1 Reset: rst=1 with both valids high 3 cycles -> all ready/rsp_valid/strobes 0.
//  2 Fetch only: if addr 0x10 at cycle N -> if_req_ready=1 at N, if_rsp_valid=1 at N+1,
//    if_rsp_data = mem[0x10].
//  3 Contention: both valid, dm read 0x200 -> dm granted at N, dm_rsp_valid at N+1,
//    fetch granted at N+1 once dm_req_valid drops.
//  4 Write: dm write 0xDEADBEEF be=4'b0011 to 0x40 -> mem_wr_en=1, mem_be=0011,
//    no rsp_valid next cycle; later read of 0x40 returns 0x0000BEEF over prior 0.
//  5 Starvation (guard on, MAX_DM_BURST=4): both held valid -> dm granted 4 cycles,
//    fetch granted cycle 5, dm again cycle 6; guard off -> fetch never granted.
//  6 Reset mid-read: rst at cycle after fetch grant -> if_rsp_valid stays 0.

Source files
------------

// File: rtl/rv_mem_arb_if.sv
// Bus bundle for rv_mem_arb: fetch request/response, data request/response, and the
// single-port memory side. The arbiter uses the slave modport; the core and memory use master.
interface rv_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              dm_req_valid;
  logic [ADDR_W-1:0] dm_req_addr;
  logic              dm_req_wr_en;
  logic [DATA_W-1:0] dm_req_wr_data;
  logic [BE_W-1:0]   dm_req_be;
  logic              dm_req_ready;
  logic              dm_rsp_valid;
  logic [DATA_W-1:0] dm_rsp_data;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_valid, dm_req_addr, dm_req_wr_en, dm_req_wr_data, dm_req_be,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_be,
    input  mem_rd_data
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_valid, dm_req_addr, dm_req_wr_en, dm_req_wr_data, dm_req_be,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, mem_be,
    output mem_rd_data
  );
endinterface

// File: rtl/rv_mem_arb.sv
// Fetch/data arbiter for one single-port 1-cycle-latency memory; data port has priority.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch wait to MAX_DM_BURST consecutive data grants.
module rv_mem_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DM_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  rv_mem_arb_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_DM   = 2'd2
  } rsp_sel_e;

  rsp_sel_e          rsp_sel_d, rsp_sel_q;
  logic              force_if;
  logic              gnt_dm, gnt_if;
  logic              mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [BE_W-1:0]   mem_be;

  if (MAX_DM_BURST < 1) begin : g_param_chk
    $error("rv_mem_arb: MAX_DM_BURST must be at least 1");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int               CNT_W   = $clog2(MAX_DM_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DM_BURST);

  logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;

  // Once fetch has watched MAX_DM_BURST data grants in a row it takes the next slot.
  assign force_if = bus.if_req_valid & (starve_cnt_q == CNT_MAX);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.if_req_valid || gnt_if) begin
      starve_cnt_d = '0;
    end else if (gnt_dm && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    gnt_dm      = ~rst & bus.dm_req_valid & ~force_if;
    gnt_if      = ~rst & bus.if_req_valid & ~gnt_dm;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_be      = '0;
    rsp_sel_d   = RSP_NONE;
    if (gnt_dm) begin
      mem_addr    = bus.dm_req_addr;
      mem_wr_data = bus.dm_req_wr_data;
      mem_be      = bus.dm_req_be;
      mem_wr_en   = bus.dm_req_wr_en;
      mem_rd_en   = ~bus.dm_req_wr_en;
      rsp_sel_d   = bus.dm_req_wr_en ? RSP_NONE : RSP_DM;
    end else if (gnt_if) begin
      mem_addr  = bus.if_req_addr;
      mem_rd_en = 1'b1;
      mem_be    = '1;
      rsp_sel_d = RSP_IF;
    end
  end

  // Remembers who owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) rsp_sel_q <= RSP_NONE;
    else     rsp_sel_q <= rsp_sel_d;
  end

  assign bus.if_req_ready = gnt_if;
  assign bus.dm_req_ready = gnt_dm;
  assign bus.mem_rd_en    = mem_rd_en;
  assign bus.mem_wr_en    = mem_wr_en;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wr_data  = mem_wr_data;
  assign bus.mem_be       = mem_be;

  // A response in flight when reset hits is dropped, not delivered.
  assign bus.if_rsp_valid = ~rst & (rsp_sel_q == RSP_IF);
  assign bus.dm_rsp_valid = ~rst & (rsp_sel_q == RSP_DM);
  assign bus.if_rsp_data  = bus.mem_rd_data;
  assign bus.dm_rsp_data  = bus.mem_rd_data;
endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb: vector table plus reset, starvation and mid-read reset sequences.
// Memory model: word at byte address A holds 32'hC0DE_0000 | A, except 0x40 which starts at 0.
module tb_rv_mem_arb;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rv_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv_mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_DM_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | (i << 2);
      mem[16] <= 32'h0;
    end else if (bus.mem_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
    end
    if (bus.mem_rd_en) rd_q <= mem[bus.mem_addr[9:2]];
  end
  assign bus.mem_rd_data = rd_q;

  typedef struct {
    logic        if_v;
    logic [31:0] if_a;
    logic        dm_v;
    logic [31:0] dm_a;
    logic        dm_we;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic        x_if_rdy;
    logic        x_dm_rdy;
    logic        x_rd;
    logic        x_wr;
    logic [31:0] x_addr;
    logic [31:0] x_wd;
    logic [3:0]  x_be;
    logic        x_if_rv;
    logic        x_dm_rv;
    logic [31:0] x_rdata;
  } vec_t;

  function automatic vec_t mk(
    input logic if_v, input logic [31:0] if_a, input logic dm_v, input logic [31:0] dm_a,
    input logic dm_we, input logic [31:0] dm_wd, input logic [3:0] dm_be,
    input logic x_if_rdy, input logic x_dm_rdy, input logic x_rd, input logic x_wr,
    input logic [31:0] x_addr, input logic [31:0] x_wd, input logic [3:0] x_be,
    input logic x_if_rv, input logic x_dm_rv, input logic [31:0] x_rdata);
    vec_t v;
    v.if_v = if_v; v.if_a = if_a; v.dm_v = dm_v; v.dm_a = dm_a;
    v.dm_we = dm_we; v.dm_wd = dm_wd; v.dm_be = dm_be;
    v.x_if_rdy = x_if_rdy; v.x_dm_rdy = x_dm_rdy; v.x_rd = x_rd; v.x_wr = x_wr;
    v.x_addr = x_addr; v.x_wd = x_wd; v.x_be = x_be;
    v.x_if_rv = x_if_rv; v.x_dm_rv = x_dm_rv; v.x_rdata = x_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic if_v, input logic [31:0] if_a, input logic dm_v,
                       input logic [31:0] dm_a, input logic dm_we, input logic [31:0] dm_wd,
                       input logic [3:0] dm_be);
    bus.if_req_valid   = if_v;
    bus.if_req_addr    = if_a;
    bus.dm_req_valid   = dm_v;
    bus.dm_req_addr    = dm_a;
    bus.dm_req_wr_en   = dm_we;
    bus.dm_req_wr_data = dm_wd;
    bus.dm_req_be      = dm_be;
  endtask

  vec_t vecs [11];

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //            if_v if_a    dm_v dm_a    we wd            be    ifr dmr rd wr addr    wd            be    ifv dmv rdata
    vecs[0]  = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 32'h10, 0, 32'h0,   0, 32'h0,        4'h0, 1, 0, 1, 0, 32'h10,  32'h0,        4'hF, 0, 0, 32'h0);
    vecs[2]  = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 32'hC0DE0010);
    vecs[3]  = mk(1, 32'h20, 1, 32'h200, 0, 32'h1234,     4'h5, 0, 1, 1, 0, 32'h200, 32'h1234,     4'h5, 0, 0, 32'h0);
    vecs[4]  = mk(1, 32'h20, 0, 32'h0,   0, 32'h0,        4'h0, 1, 0, 1, 0, 32'h20,  32'h0,        4'hF, 0, 1, 32'hC0DE0200);
    vecs[5]  = mk(0, 32'h0,  1, 32'h40,  1, 32'hDEADBEEF, 4'h3, 0, 1, 0, 1, 32'h40,  32'hDEADBEEF, 4'h3, 1, 0, 32'hC0DE0020);
    vecs[6]  = mk(0, 32'h0,  1, 32'h40,  0, 32'h0,        4'h0, 0, 1, 1, 0, 32'h40,  32'h0,        4'h0, 0, 0, 32'h0);
    vecs[7]  = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 1, 32'h0000BEEF);
    vecs[8]  = mk(1, 32'h10, 0, 32'h0,   0, 32'h0,        4'h0, 1, 0, 1, 0, 32'h10,  32'h0,        4'hF, 0, 0, 32'h0);
    vecs[9]  = mk(1, 32'h44, 0, 32'h0,   0, 32'h0,        4'h0, 1, 0, 1, 0, 32'h44,  32'h0,        4'hF, 1, 0, 32'hC0DE0010);
    vecs[10] = mk(0, 32'h0,  0, 32'h0,   0, 32'h0,        4'h0, 0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 32'hC0DE0044);

    // Reset held three cycles with both requesters active.
    rst = 1'b1;
    drive(1, 32'h10, 1, 32'h200, 0, 32'h0, 4'hF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset c%0d rdy/rv/strobes", c),
          {bus.if_req_ready, bus.dm_req_ready, bus.if_rsp_valid, bus.dm_rsp_valid,
           bus.mem_rd_en, bus.mem_wr_en}, 6'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].if_v, vecs[i].if_a, vecs[i].dm_v, vecs[i].dm_a,
            vecs[i].dm_we, vecs[i].dm_wd, vecs[i].dm_be);
      #1;
      chk($sformatf("v%0d ready", i), {bus.if_req_ready, bus.dm_req_ready},
          {vecs[i].x_if_rdy, vecs[i].x_dm_rdy});
      chk($sformatf("v%0d strobes", i), {bus.mem_rd_en, bus.mem_wr_en},
          {vecs[i].x_rd, vecs[i].x_wr});
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, vecs[i].x_addr);
      chk($sformatf("v%0d mem_wr_data", i), bus.mem_wr_data, vecs[i].x_wd);
      chk($sformatf("v%0d mem_be", i), bus.mem_be, vecs[i].x_be);
      chk($sformatf("v%0d rsp_valid", i), {bus.if_rsp_valid, bus.dm_rsp_valid},
          {vecs[i].x_if_rv, vecs[i].x_dm_rv});
      if (vecs[i].x_if_rv)
        chk($sformatf("v%0d if_rsp_data", i), bus.if_rsp_data, vecs[i].x_rdata);
      if (vecs[i].x_dm_rv)
        chk($sformatf("v%0d dm_rsp_data", i), bus.dm_rsp_data, vecs[i].x_rdata);
      @(negedge clk);
    end

    // Both requesters held for 8 cycles.
    drive(1, 32'h10, 1, 32'h200, 0, 32'h0, 4'h0);
    for (int c = 0; c < 8; c++) begin
      logic exp_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_if = (c == 4);
`else
      exp_if = 1'b0;
`endif
      #1;
      chk($sformatf("starve c%0d ready", c), {bus.if_req_ready, bus.dm_req_ready},
          {exp_if, ~exp_if});
      @(negedge clk);
    end
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0);
    @(negedge clk);

    // Reset the cycle after a fetch grant: its response must never appear.
    drive(1, 32'h10, 0, 32'h0, 0, 32'h0, 4'h0);
    #1;
    chk("midrst grant", bus.if_req_ready, 1'b1);
    @(negedge clk);
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0);
    rst = 1'b1;
    #1;
    chk("midrst rsp during rst", {bus.if_rsp_valid, bus.dm_rsp_valid}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst rsp after rst", {bus.if_rsp_valid, bus.dm_rsp_valid}, 2'b00);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
